// File: rtl/fht_input_loader_pkg.sv
// fht_input_loader_pkg
// Constants, the loader state encoding and the bit-reverse helper shared by
// the input loader and the FHT stage controller.
//   A_BIT  : per-bank address width (256 words per bank)
//   D_BIT  : sample width
//   N_BIT  : frame index width (N = 2^N_BIT points spread over N_BANK banks)
//   N_BANK : number of RAM banks, selected by the two LSBs of the reversed index
package fht_input_loader_pkg;

  localparam int A_BIT  = 8;
  localparam int D_BIT  = 16;
  localparam int N_BIT  = A_BIT + 2;
  localparam int N_BANK = 4;
  localparam int N_PTS  = 1 << N_BIT;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_KICK      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  // Pure wire permutation: bit i of the result is bit N_BIT-1-i of the input.
  function automatic logic [N_BIT-1:0] bit_rev(input logic [N_BIT-1:0] i_val);
    logic [N_BIT-1:0] v_rev;
    for (int i = 0; i < N_BIT; i++) begin
      v_rev[i] = i_val[N_BIT-1-i];
    end
    return v_rev;
  endfunction

endpackage

// File: rtl/fht_input_loader.sv
// fht_input_loader
// Collects one frame of N time-domain samples from a valid/ready stream and
// writes them into four RAM banks in bit-reversed order, then pulses the FHT
// controller's start and waits for the transform to finish.
//
// Handshake: a sample transfers on a rising clock edge where iVALID and oREADY
// are both high. oREADY is high only in LOAD while the controller reports
// idle (iFHT_RDY=1); iVALID while oREADY is low is ignored entirely.
//
// Ports:
//   iCLK      clock
//   iRESET    asynchronous active-high reset
//   iVALID    input sample valid
//   iDATA     input sample
//   oREADY    loader accepts a sample this cycle
//   oWR_ADDR  bank write address, shared by all banks
//   oWR_DATA  bank write data
//   oWE       one-hot bank write enable (bit b selects bank b)
//   oSTART    one-cycle start pulse to the FHT controller
//   iFHT_RDY  ready/idle flag from the FHT controller
//   oBUSY     frame handed off, transform in progress
//   oCNT      samples accepted in the current frame
//   oSTATE    current FSM state (debug visibility)
module fht_input_loader
  import fht_input_loader_pkg::*;
(
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iVALID,
  input  logic [D_BIT-1:0]  iDATA,
  output logic              oREADY,
  output logic [A_BIT-1:0]  oWR_ADDR,
  output logic [D_BIT-1:0]  oWR_DATA,
  output logic [N_BANK-1:0] oWE,
  output logic              oSTART,
  input  logic              iFHT_RDY,
  output logic              oBUSY,
  output logic [N_BIT-1:0]  oCNT,
  output state_t            oSTATE
);

  state_t            r_state;
  state_t            w_next;
  logic              w_ready;
  logic              w_start;
  logic              w_busy;
  logic              w_accept;
  logic              w_last;
  logic [N_BIT-1:0]  r_cnt;
  logic [N_BIT-1:0]  w_rev;
  logic [N_BANK-1:0] w_bank_sel;
  logic [N_BANK-1:0] r_we;
  logic [A_BIT-1:0]  r_addr;
  logic [D_BIT-1:0]  r_data;

  assign w_accept = iVALID & w_ready;
  assign w_last   = (r_cnt == {N_BIT{1'b1}});
  assign w_rev    = bit_rev(r_cnt);

  // Bank select from the two LSBs of the reversed index.
  always_comb begin
    w_bank_sel = '0;
    w_bank_sel[w_rev[1:0]] = 1'b1;
  end

  // State register.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_start = 1'b0;
    w_busy  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iFHT_RDY) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        // Gated by iFHT_RDY so an external start never lets a sample slip in.
        w_ready = iFHT_RDY;
        if (!iFHT_RDY) begin
          w_next = ST_IDLE;
        end else if (w_accept && w_last) begin
          w_next = ST_KICK;
        end
      end
      ST_KICK: begin
        w_start = 1'b1;
        w_next  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        w_busy = 1'b1;
        if (!iFHT_RDY) w_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        w_busy = 1'b1;
        if (iFHT_RDY) w_next = ST_LOAD;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Sample counter. Outside an active LOAD it is held at zero, which also
  // discards a partial frame when the controller drops iFHT_RDY. The
  // increment past N-1 wraps to zero on the LOAD -> KICK edge by itself.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_cnt <= '0;
    end else if ((r_state != ST_LOAD) || !iFHT_RDY) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + N_BIT'(1);
    end
  end

  // Registered bank write, one cycle after acceptance. Address and data hold
  // their last values between writes; only the enable returns to zero.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_we   <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= '0;
      if (w_accept) begin
        r_we   <= w_bank_sel;
        r_addr <= w_rev[N_BIT-1:2];
        r_data <= iDATA;
      end
    end
  end

  assign oREADY   = w_ready;
  assign oSTART   = w_start;
  assign oBUSY    = w_busy;
  assign oWE      = r_we;
  assign oWR_ADDR = r_addr;
  assign oWR_DATA = r_data;
  assign oCNT     = r_cnt;
  assign oSTATE   = r_state;

endmodule

// File: tb/tb_fht_input_loader.sv
// tb_fht_input_loader
// Directed bench for fht_input_loader: bit-reversed bank mapping, write
// latency, frame hand-off to a modelled FHT controller, input gaps, reset
// mid-frame and an external start dropping iFHT_RDY mid-load.
module tb_fht_input_loader;
  import fht_input_loader_pkg::*;

  localparam int N = N_PTS;
  localparam int W = N_BANK + A_BIT + D_BIT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              iVALID;
  logic [D_BIT-1:0]  iDATA;
  logic              iFHT_RDY;
  logic              oREADY;
  logic [A_BIT-1:0]  oWR_ADDR;
  logic [D_BIT-1:0]  oWR_DATA;
  logic [N_BANK-1:0] oWE;
  logic              oSTART;
  logic              oBUSY;
  logic [N_BIT-1:0]  oCNT;
  state_t            oSTATE;

  fht_input_loader dut (
    .iCLK     (clk),
    .iRESET   (rst),
    .iVALID   (iVALID),
    .iDATA    (iDATA),
    .oREADY   (oREADY),
    .oWR_ADDR (oWR_ADDR),
    .oWR_DATA (oWR_DATA),
    .oWE      (oWE),
    .oSTART   (oSTART),
    .iFHT_RDY (iFHT_RDY),
    .oBUSY    (oBUSY),
    .oCNT     (oCNT),
    .oSTATE   (oSTATE)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference helpers.
  function automatic logic [N_BIT-1:0] tb_rev(input int k);
    logic [N_BIT-1:0] v = '0;
    int src = k;
    for (int i = N_BIT - 1; i >= 0; i--) begin
      v[i] = src[0];
      src = src >> 1;
    end
    return v;
  endfunction

  function automatic logic [D_BIT-1:0] dat(input int k);
    return D_BIT'(k * 37 + 'h1234);
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int tb_k = 0;
  int n_start = 0;
  int hits[N_BANK][256];
  logic [D_BIT-1:0] mem[N_BANK][256];
  logic [D_BIT-1:0] mem1[N_BANK][256];

  // Sampled on the falling edge: inputs for the next rising edge are stable
  // and outputs reflect the previous rising edge.
  always @(negedge clk) begin
    logic [W-1:0]       w;
    logic [N_BIT-1:0]   r;
    logic [N_BANK-1:0]  oh;
    int b;
    if (rst) begin
      exp_q.delete();
      tb_k = 0;
    end else begin
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("wr_we",   32'(oWE),      32'(w[W-1 -: N_BANK]));
        check("wr_addr", 32'(oWR_ADDR), 32'(w[D_BIT +: A_BIT]));
        check("wr_data", 32'(oWR_DATA), 32'(w[D_BIT-1:0]));
      end else begin
        check("we_quiet", 32'(oWE), 32'd0);
      end
      case (oWE)
        4'b0001: b = 0;
        4'b0010: b = 1;
        4'b0100: b = 2;
        4'b1000: b = 3;
        default: b = -1;
      endcase
      if (b >= 0) begin
        hits[b][oWR_ADDR]++;
        mem[b][oWR_ADDR] = oWR_DATA;
      end
      if (oSTART) n_start++;
      check("cnt", 32'(oCNT), 32'(tb_k));
      if (!iFHT_RDY) begin
        tb_k = 0;
      end else if (iVALID && oREADY) begin
        r  = tb_rev(tb_k);
        oh = N_BANK'(1) << r[1:0];
        exp_q.push_back({oh, r[N_BIT-1:2], iDATA});
        tb_k = (tb_k + 1) % N;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_dir(input int k);
    logic [N_BANK-1:0] we;
    logic [A_BIT-1:0]  ad;
    bit found = 1'b1;
    case (k)
      0:       begin we = 4'b0001; ad = 8'd0;   end
      1:       begin we = 4'b0001; ad = 8'd128; end
      2:       begin we = 4'b0001; ad = 8'd64;  end
      256:     begin we = 4'b0100; ad = 8'd0;   end
      768:     begin we = 4'b1000; ad = 8'd0;   end
      1023:    begin we = 4'b1000; ad = 8'd255; end
      default: begin we = '0; ad = '0; found = 1'b0; end
    endcase
    if (found) begin
      check($sformatf("dir_we_k%0d", k),   32'(oWE),      32'(we));
      check($sformatf("dir_addr_k%0d", k), 32'(oWR_ADDR), 32'(ad));
      check($sformatf("dir_data_k%0d", k), 32'(oWR_DATA), 32'(dat(k)));
    end
  endtask

  // Offers samples k=0.. until stop_at have been accepted; gap is the
  // percentage of cycles with iVALID low. Returns at 1 ns after the edge
  // that accepted the last one.
  task automatic feed(input int stop_at, input int gap);
    int k = 0;
    int cyc = 0;
    logic acc;
    while (k < stop_at && cyc < 8 * N) begin
      iVALID = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
      iDATA  = dat(k);
      @(negedge clk);
      acc = iVALID && oREADY;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        check_dir(k);
        k++;
      end
    end
    iVALID = 1'b0;
    if (k < stop_at) check("feed_timeout", 32'(k), 32'(stop_at));
  endtask

  task automatic frame_end_checks(input string tag);
    check({tag, "_ready"}, 32'(oREADY), 32'd0);
    check({tag, "_start"}, 32'(oSTART), 32'd1);
    check({tag, "_cnt"},   32'(oCNT),   32'd0);
    check({tag, "_state"}, 32'(oSTATE), 32'(ST_KICK));
  endtask

  // FHT controller model: drops iFHT_RDY one cycle after start, holds it low
  // for busy_cycles while junk is offered on the input, then raises it.
  task automatic ctrl(input string tag, input int busy_cycles);
    int bad_busy = 0;
    int bad_ready = 0;
    @(posedge clk); #1;
    check({tag, "_busy_early"}, 32'(oBUSY),  32'd1);
    check({tag, "_start_once"}, 32'(oSTART), 32'd0);
    check({tag, "_wait_busy"},  32'(oSTATE), 32'(ST_WAIT_BUSY));
    iFHT_RDY = 1'b0;
    for (int i = 0; i < busy_cycles; i++) begin
      iVALID = 1'b1;
      iDATA  = D_BIT'($urandom);
      @(posedge clk); #1;
      if (oBUSY !== 1'b1)  bad_busy++;
      if (oREADY !== 1'b0) bad_ready++;
    end
    check({tag, "_busy_hold"},  32'(bad_busy),  32'd0);
    check({tag, "_ready_hold"}, 32'(bad_ready), 32'd0);
    iVALID   = 1'b0;
    iFHT_RDY = 1'b1;
    check({tag, "_ready_not_yet"}, 32'(oREADY), 32'd0);
    @(posedge clk); #1;
    check({tag, "_ready_back"}, 32'(oREADY), 32'd1);
    check({tag, "_busy_clear"}, 32'(oBUSY),  32'd0);
    check({tag, "_load"},       32'(oSTATE), 32'(ST_LOAD));
  endtask

  task automatic clear_cover();
    for (int b = 0; b < N_BANK; b++)
      for (int a = 0; a < 256; a++) begin
        hits[b][a] = 0;
        mem[b][a]  = '0;
      end
  endtask

  task automatic check_cover(input string tag);
    int bad_hits = 0;
    int bad_data = 0;
    int per_bank[N_BANK];
    logic [N_BIT-1:0] r;
    for (int b = 0; b < N_BANK; b++) begin
      per_bank[b] = 0;
      for (int a = 0; a < 256; a++) begin
        per_bank[b] += hits[b][a];
        if (hits[b][a] != 1) bad_hits++;
      end
      check($sformatf("%s_bank%0d_writes", tag, b), 32'(per_bank[b]), 32'd256);
    end
    for (int k = 0; k < N; k++) begin
      r = tb_rev(k);
      if (mem[r[1:0]][r[N_BIT-1:2]] !== dat(k)) bad_data++;
    end
    check({tag, "_addr_once"}, 32'(bad_hits), 32'd0);
    check({tag, "_contents"},  32'(bad_data), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int diff;
    rst      = 1'b1;
    iVALID   = 1'b0;
    iDATA    = '0;
    iFHT_RDY = 1'b0;
    clear_cover();
    repeat (3) @(posedge clk); #1;
    check("rst_ready", 32'(oREADY),   32'd0);
    check("rst_we",    32'(oWE),      32'd0);
    check("rst_addr",  32'(oWR_ADDR), 32'd0);
    check("rst_data",  32'(oWR_DATA), 32'd0);
    check("rst_start", 32'(oSTART),   32'd0);
    check("rst_busy",  32'(oBUSY),    32'd0);
    check("rst_cnt",   32'(oCNT),     32'd0);
    check("rst_state", 32'(oSTATE),   32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_no_rdy", 32'(oSTATE), 32'(ST_IDLE));
    iFHT_RDY = 1'b1;
    @(posedge clk); #1;
    check("load_ready", 32'(oREADY), 32'd1);

    // Frame 1: continuous valid.
    s0 = n_start;
    feed(N, 0);
    frame_end_checks("f1_end");
    ctrl("f1_ctrl", 2580);
    check("f1_one_start", 32'(n_start - s0), 32'd1);
    check_cover("f1");
    for (int b = 0; b < N_BANK; b++)
      for (int a = 0; a < 256; a++) mem1[b][a] = mem[b][a];

    // Frame 2: 50% valid gaps; must land exactly where frame 1 did.
    clear_cover();
    s0 = n_start;
    feed(N, 50);
    frame_end_checks("f2_end");
    ctrl("f2_ctrl", 20);
    check("f2_one_start", 32'(n_start - s0), 32'd1);
    check_cover("f2");
    diff = 0;
    for (int b = 0; b < N_BANK; b++)
      for (int a = 0; a < 256; a++) if (mem[b][a] !== mem1[b][a]) diff++;
    check("f2_match_f1", 32'(diff), 32'd0);

    // Reset mid-frame at k=500.
    feed(500, 0);
    check("pre_rst_cnt", 32'(oCNT), 32'd500);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(oREADY),   32'd0);
    check("mid_rst_we",    32'(oWE),      32'd0);
    check("mid_rst_addr",  32'(oWR_ADDR), 32'd0);
    check("mid_rst_data",  32'(oWR_DATA), 32'd0);
    check("mid_rst_start", 32'(oSTART),   32'd0);
    check("mid_rst_busy",  32'(oBUSY),    32'd0);
    check("mid_rst_cnt",   32'(oCNT),     32'd0);
    check("mid_rst_state", 32'(oSTATE),   32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // External start at k=10: partial frame discarded, no start pulse.
    s0 = n_start;
    feed(10, 0);
    check("drop_cnt_before", 32'(oCNT), 32'd10);
    iFHT_RDY = 1'b0;
    iVALID   = 1'b1;
    iDATA    = 16'hDEAD;
    #1;
    check("drop_ready_now", 32'(oREADY), 32'd0);
    repeat (5) @(posedge clk); #1;
    check("drop_cnt",   32'(oCNT),   32'd0);
    check("drop_ready", 32'(oREADY), 32'd0);
    check("drop_state", 32'(oSTATE), 32'(ST_IDLE));
    check("drop_no_start", 32'(n_start - s0), 32'd0);
    iVALID   = 1'b0;
    iFHT_RDY = 1'b1;

    // Resume: full frame from k=0.
    clear_cover();
    s0 = n_start;
    feed(N, 0);
    frame_end_checks("f3_end");
    ctrl("f3_ctrl", 20);
    check("f3_one_start", 32'(n_start - s0), 32'd1);
    check_cover("f3");

    repeat (2) @(posedge clk); #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fht_input_loader.md
Name: fht_input_loader

Overview:
- Upstream neighbour of the FHT stage controller.
- Accepts a stream of N time-domain samples over a valid/ready handshake and writes them into the four RAM banks in bit-reversed order, as the zero stage expects.
- When the frame is complete it pulses the controller's start input, then waits for the transform to finish before accepting the next frame.

Parameters:
- A_BIT, 8, per-bank address width (256 words per bank).
- D_BIT, 16, sample width.
- N_BIT, A_BIT+2, frame index width (N = 2^N_BIT = 1024 points across 4 banks).

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous, active-high reset.
- iVALID  in  1  input sample valid.
- iDATA  in  D_BIT  input sample.
- oREADY  out  1  loader accepts a sample this cycle.
- oWR_ADDR  out  A_BIT  bank write address, shared by all banks.
- oWR_DATA  out  D_BIT  bank write data.
- oWE  out  4  one-hot bank write enable; bit b selects bank b.
- oSTART  out  1  one-cycle start pulse to the FHT controller.
- iFHT_RDY  in  1  ready/idle flag from the FHT controller.
- oBUSY  out  1  frame handed off, transform in progress.
- oCNT  out  N_BIT  samples accepted in the current frame.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: oREADY=0, oWE=0, oWR_ADDR=0, oWR_DATA=0, oSTART=0, oBUSY=0, oCNT=0, state=IDLE.
- States:
  - IDLE: go to LOAD when iFHT_RDY=1.
  - LOAD: oREADY=1.
  - KICK: oSTART=1 for exactly one cycle.
  - WAIT_BUSY: wait for iFHT_RDY=0.
  - WAIT_DONE: oBUSY=1; wait for iFHT_RDY=1.
- Acceptance:
  - A sample is accepted when iVALID & oREADY.
  - Index k = oCNT before increment.
  - r = bit-reverse of k over N_BIT bits.
  - Bank b = r[1:0]; address = r[N_BIT-1:2].
- Write latency: 1 cycle. In the cycle after acceptance, oWE has bit b set, oWR_ADDR = r[N_BIT-1:2], and oWR_DATA = the registered sample. Otherwise oWE=0 and addr/data hold their last values.
- Frame end:
  - On acceptance of k = N-1, oREADY drops in the next cycle and the state goes to KICK.
  - The last write and oSTART may coincide; the controller samples start only after the write has been issued.
- oCNT:
  - Increments on each acceptance.
  - Wraps to 0 on the transition LOAD -> KICK.
  - Holds 0 in KICK, WAIT_BUSY and WAIT_DONE.
- WAIT_BUSY: no timeout; oBUSY is set from WAIT_BUSY onward.
- WAIT_DONE -> LOAD on iFHT_RDY=1; oBUSY clears on the same edge.
- iVALID while oREADY=0: ignored, with no write and no count.
- iFHT_RDY dropping in IDLE or LOAD (external start): the loader stays in or returns to IDLE, oREADY=0, and oCNT is cleared. A partially loaded frame is discarded.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). RAM contents are not cleared.
- All arithmetic is unsigned. Bit reversal is purely a wire permutation, computed combinationally from oCNT.

Decomposition:
- Shared package holds:
  - constants N_BIT, A_BIT, D_BIT, N_BANK=4;
  - the state enum (IDLE, LOAD, KICK, WAIT_BUSY, WAIT_DONE);
  - the bit-reverse function, which is also used by the controller's coefficient addressing.
- No sub-module. The bank/address mapper is small enough to remain a function.

Test Plan:
- Reset, then iFHT_RDY=1 with continuous iVALID:
  - k=0 -> oWE=0001, addr 0.
  - k=1 -> oWE=0001, addr 128.
  - k=2 -> oWE=0001, addr 64.
  - k=256 -> oWE=0100, addr 0.
  - k=768 -> oWE=1000, addr 0.
  - k=1023 -> oWE=1000, addr 255.
  - Each write appears exactly 1 cycle after acceptance.
- Full frame of 1024 samples:
  - oREADY low from the cycle after k=1023;
  - a single oSTART pulse;
  - oCNT=0;
  - each bank receives exactly 256 writes, covering every address once.
- Controller model drops iFHT_RDY 1 cycle after oSTART and raises it 2580 cycles later:
  - oBUSY high throughout;
  - oREADY returns 1 cycle after iFHT_RDY rises;
  - iVALID during the busy period is ignored.
- Random iVALID gaps (50%): write data and addresses match the gap-free run; oCNT counts only handshakes.
- Assert iRESET at k=500:
  - all outputs at reset values in the same cycle;
  - after release, the next frame restarts at k=0, bank 0, addr 0.
- iFHT_RDY forced low at k=10 in LOAD: oREADY=0, oCNT=0, no oSTART; resume at k=0 when iFHT_RDY returns to 1.
